// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encodings (also used by the comparison harness)
// and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_half_adder.sv
// half_adder: the existing 1-bit full-adder cell (the historical name is kept
// for compatibility with the adder-comparison design).
// Ports:
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out
module half_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one bit per clock, using a
// single shared full-adder cell. Result appears WIDTH edges after the
// accepting edge with a one-cycle done pulse.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin an addition (sampled only while idle)
//   a, b, cin     : operands and carry-in, captured on the accepting edge
//   busy          : high while running or presenting the result
//   done          : one-cycle result-valid pulse
//   sum, cout     : registered result, held until the next accepted start
//   ovf           : registered two's-complement overflow
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_s, cell_cout;

  half_adder u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = cell_cout;
        if (cnt_q == LastCnt) begin
          // carry_q here is the carry into the MSB
          cout_d  = cell_cout;
          ovf_d   = carry_q ^ cell_cout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  exp_t sb[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compare against the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.o));
        chk("latency", 32'(cyc - e.t), 32'd8);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, input logic eo, input bit push);
    wait_idle();
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    if (push) sb.push_back('{s: es, c: ec, o: eo, t: cyc});
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  // Returns just after the edge that ends the done cycle.
  task automatic wait_done(input logic [W-1:0] es);
    int n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk);
      #1;
      chk("busy_fall", 32'(busy), 32'd0);
      chk("done_pulse", 32'(done), 32'd0);
      chk("sum_held", 32'(sum), 32'(es));
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  vec_t vecs[7] = '{
    '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
    '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b1);
      wait_done(vecs[i].s);
    end

    // Start during RUN must be ignored.
    d0 = done_cnt;
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(8'h46);
    repeat (14) @(posedge clk);
    #1;
    chk("one_done_pulse", 32'(done_cnt - d0), 32'd1);

    // Reset mid-RUN: immediate clear, no done for the aborted op.
    d0 = done_cnt;
    issue(8'h33, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
    wait_done(8'h03);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
